issue_queue_nway: RTL and testbench

//  Parametrised in-order instruction buffer between the decode stage and dispatch.

---
 rtl/issue_queue_nway_if.sv | 29 ++
 rtl/issue_queue_nway.sv | 91 +++++++++
 tb/tb_issue_queue_nway.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_nway_if.sv
// Decode-to-dispatch bundle for the N-way issue queue.
// master = decode/dispatch side, slave = queue.
interface issue_queue_nway_if #(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DATA_W    = 64
);
  logic                           flush;
  logic                           pause;
  logic [IN_WIDTH-1:0]            in_valid;
  logic [IN_WIDTH*DATA_W-1:0]     in_data;
  logic                           in_ready;
  logic [OUT_WIDTH-1:0]           out_valid;
  logic [OUT_WIDTH*DATA_W-1:0]    out_data;
  logic [$clog2(OUT_WIDTH+1)-1:0] pop_num;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           pop_err;

  modport master (
    output flush, pause, in_valid, in_data, pop_num,
    input  in_ready, out_valid, out_data, count, pop_err
  );

  modport slave (
    input  flush, pause, in_valid, in_data, pop_num,
    output in_ready, out_valid, out_data, count, pop_err
  );
endinterface

// File: rtl/issue_queue_nway.sv
// In-order circular issue queue: IN_WIDTH compacted pushes, 0..OUT_WIDTH pops per cycle.
// Show-ahead outputs from registered state; new entries visible the cycle after the write.
module issue_queue_nway #(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DATA_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  issue_queue_nway_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PSH_W = $clog2(IN_WIDTH+1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - IN_WIDTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  pop_ext;
  logic [CNT_W-1:0]  eff_pop;
  logic [CNT_W-1:0]  count_next;
  logic [PSH_W-1:0]  push_n;
  logic [IN_WIDTH-1:0] wr_en;
  logic [PTR_W-1:0]  wr_idx [IN_WIDTH];
  logic              accept;
  logic              over_pop;
  logic              pop_err_r;

  // Space check uses registered count only, so a same-cycle pop never frees room.
  assign q.in_ready = (count_r <= READY_MAX);
  assign accept     = q.in_ready & ~q.flush;

  assign pop_ext    = CNT_W'(q.pop_num);
  assign over_pop   = ~q.pause & (pop_ext > count_r);
  assign eff_pop    = q.pause ? '0 : (over_pop ? count_r : pop_ext);
  assign count_next = count_r + CNT_W'(push_n) - eff_pop;

  // Valid lanes are packed into consecutive slots starting at tail.
  always_comb begin
    push_n = '0;
    wr_en  = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_idx[i] = tail + PTR_W'(push_n);
      if (accept && q.in_valid[i]) begin
        wr_en[i] = 1'b1;
        push_n   = push_n + PSH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      head    <= head + PTR_W'(eff_pop);
      tail    <= tail + PTR_W'(push_n);
      count_r <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_err_r <= 1'b0;
    end else if (over_pop) begin
      pop_err_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (!rst && wr_en[i]) begin
        mem[wr_idx[i]] <= q.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_out
    logic lane_vld;
    assign lane_vld                     = (count_r > CNT_W'(j));
    assign q.out_valid[j]               = lane_vld;
    assign q.out_data[j*DATA_W +: DATA_W] = lane_vld ? mem[head + PTR_W'(j)] : '0;
  end

  assign q.count   = count_r;
  assign q.pop_err = pop_err_r;
endmodule

// File: tb/tb_issue_queue_nway.sv
// Randomized and directed checks of issue_queue_nway against a queue-based reference model.
module tb_issue_queue_nway;
  localparam int DEPTH = 8;
  localparam int IW    = 2;
  localparam int OW    = 2;
  localparam int DW    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mq[$];
  logic          merr = 1'b0;

  issue_queue_nway_if #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DATA_W(DW)) bus ();

  issue_queue_nway #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic f, input logic p, input logic [IW-1:0] v,
                       input logic [IW*DW-1:0] d, input logic [1:0] pn);
    bus.flush    = f;
    bus.pause    = p;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.pop_num  = pn;
  endtask

  // Advances one clock; the model applies the rules to the inputs sampled at that edge.
  task automatic tick();
    int sz;
    int ep;
    int pn;
    @(posedge clk);
    sz = mq.size();
    pn = int'(bus.pop_num);
    if (rst) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (!bus.pause && pn > sz) merr = 1'b1;
      if (bus.flush) begin
        mq.delete();
      end else begin
        ep = bus.pause ? 0 : ((pn > sz) ? sz : pn);
        for (int k = 0; k < ep; k++) void'(mq.pop_front());
        if (DEPTH - sz >= IW)
          for (int i = 0; i < IW; i++)
            if (bus.in_valid[i]) mq.push_back(bus.in_data[i*DW +: DW]);
      end
    end
    #1;
  endtask

  function automatic logic [OW-1:0] exp_valid();
    logic [OW-1:0] v;
    for (int j = 0; j < OW; j++) v[j] = (mq.size() > j);
    return v;
  endfunction

  function automatic logic [OW*DW-1:0] exp_data();
    logic [OW*DW-1:0] d;
    d = '0;
    for (int j = 0; j < OW; j++) if (mq.size() > j) d[j*DW +: DW] = mq[j];
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.pop_err !== 1'b0) begin errors++; $display("FAIL reset_pop_err got=%b exp=0", bus.pop_err); end
  endtask

  task automatic test_push_basic();
    logic [DW-1:0] a = 64'hAAAA_0000_0000_0001;
    logic [DW-1:0] b = 64'hBBBB_0000_0000_0002;
    do_reset();
    drive(1'b0, 1'b0, 2'b11, {b, a}, 2'd0);
    tick();
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL push_count got=%0d exp=2", bus.count); end
    checks++; if (bus.out_data !== {b, a}) begin errors++; $display("FAIL push_data got=%h exp=%h", bus.out_data, {b, a}); end
    checks++; if (bus.out_valid !== 2'b11) begin errors++; $display("FAIL push_valid got=%b exp=11", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL push_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 2'b11, {64'(2*c+1) | 64'h1000, 64'(2*c) | 64'h1000}, 2'd0);
      tick();
    end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", bus.in_ready); end
    drive(1'b0, 1'b0, 2'b11, {64'hDEAD, 64'hBEEF}, 2'd0);
    tick();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_overflow_count got=%0d exp=8", bus.count); end
    checks++; if (bus.out_data !== {64'h1001, 64'h1000}) begin errors++; $display("FAIL fill_head got=%h exp=%h", bus.out_data, {64'h1001, 64'h1000}); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] x = 64'h5858;
    logic [DW-1:0] y = 64'h5959;
    test_fill();
    drive(1'b0, 1'b0, 2'b11, {y, x}, 2'd2);
    tick();
    checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL fullpp_count got=%0d exp=6", bus.count); end
    checks++; if (bus.out_data !== {64'h1003, 64'h1002}) begin errors++; $display("FAIL fullpp_data got=%h exp=%h", bus.out_data, {64'h1003, 64'h1002}); end
    drive(1'b0, 1'b0, 2'b11, {y, x}, 2'd0);
    tick();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fullpp_refill got=%0d exp=8", bus.count); end
    checks++; if (mq[7] !== y || mq.size() != 8) begin errors++; $display("FAIL fullpp_model_tail got=%h exp=%h", mq[7], y); end
  endtask

  task automatic test_stream();
    logic [IW*DW-1:0] d;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b0, 2'b11, {$urandom, $urandom, $urandom, $urandom}, 2'd0);
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b0, 1'b0, 2'b11, d, 2'd2);
      tick();
      checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=4", c, bus.count); end
      checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", c, bus.out_data, exp_data()); end
      checks++; if (bus.pop_err !== 1'b0) begin errors++; $display("FAIL stream_pop_err[%0d] got=%b exp=0", c, bus.pop_err); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] r = 64'h5252;
    logic [DW-1:0] s = 64'h5353;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 2'b11, {64'(c+100), 64'(c+200)}, 2'd0);
      tick();
    end
    drive(1'b0, 1'b0, 2'b00, '0, 2'd1);
    tick();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_setup got=%0d exp=5", bus.count); end
    drive(1'b1, 1'b0, 2'b11, {64'h5151, 64'h5050}, 2'd2);
    tick();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", bus.out_valid); end
    drive(1'b0, 1'b0, 2'b11, {s, r}, 2'd0);
    tick();
    checks++; if (bus.out_data[DW-1:0] !== r) begin errors++; $display("FAIL flush_refill_lane0 got=%h exp=%h", bus.out_data[DW-1:0], r); end
  endtask

  task automatic test_pop_err();
    do_reset();
    drive(1'b0, 1'b0, 2'b01, {64'h0, 64'h77}, 2'd0);
    tick();
    drive(1'b0, 1'b0, 2'b00, '0, 2'd2);
    tick();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL poperr_count got=%0d exp=0", bus.count); end
    checks++; if (bus.pop_err !== 1'b1) begin errors++; $display("FAIL poperr_set got=%b exp=1", bus.pop_err); end
    drive(1'b0, 1'b0, 2'b00, '0, 2'd0);
    tick();
    checks++; if (bus.pop_err !== 1'b1) begin errors++; $display("FAIL poperr_sticky got=%b exp=1", bus.pop_err); end
    do_reset();
    drive(1'b0, 1'b0, 2'b10, {64'h88, 64'h0}, 2'd0);
    tick();
    drive(1'b0, 1'b1, 2'b00, '0, 2'd2);
    tick();
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL pause_count got=%0d exp=1", bus.count); end
    checks++; if (bus.pop_err !== 1'b0) begin errors++; $display("FAIL pause_pop_err got=%b exp=0", bus.pop_err); end
    checks++; if (bus.out_data !== {64'h0, 64'h88}) begin errors++; $display("FAIL pause_data got=%h exp=%h", bus.out_data, {64'h0, 64'h88}); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, 2'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 2)));
      tick();
      checks++; if (bus.count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, bus.count, mq.size()); end
      checks++; if (bus.in_ready !== (DEPTH - mq.size() >= IW)) begin errors++; $display("FAIL rand_ready[%0d] got=%b", c, bus.in_ready); end
      checks++; if (bus.out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, bus.out_valid, exp_valid()); end
      checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", c, bus.out_data, exp_data()); end
      checks++; if (bus.pop_err !== merr) begin errors++; $display("FAIL rand_pop_err[%0d] got=%b exp=%b", c, bus.pop_err, merr); end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, 2'd0);
    test_reset();
    test_push_basic();
    test_fill();
    test_full_push_pop();
    test_stream();
    test_flush();
    test_pop_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
